// File: rtl/rx_bit_unstuffer.sv
// ---------------------------------------------------------------------------
// rx_bit_unstuffer
// Removes USB stuffed bits from the NRZI-decoded receive stream. After every
// run of RUN_LEN consecutive ones, the next strobed bit is a stuffed bit. That
// bit is dropped. If it is not 0, a stuff error is flagged.
//
// Parameters
//   RUN_LEN          ones per run before a stuffed bit (2..15)
//   CNT_W            run counter width, 2**CNT_W > RUN_LEN
// Ports
//   clk              system clock, rising edge
//   n_rst            asynchronous active-low reset
//   d_decoded        decoded bit, sampled when data_enable=1
//   data_enable      one-cycle strobe per received bit
//   sync_clear       synchronous packet clear (SYNC/EOP), wins over strobe
//   d_unstuffed      registered data bit, holds between strobes
//   bit_valid        one-cycle pulse, d_unstuffed carries a real bit
//   unstuff_hold     registered level, next strobed bit is a stuffed bit
//   stuff_err        sticky stuffed-bit violation flag
//   stuff_err_pulse  one-cycle pulse on the violating strobe
//   run_count        current consecutive-ones count
// ---------------------------------------------------------------------------
module rx_bit_unstuffer #(
   parameter int unsigned RUN_LEN = 6,
   parameter int unsigned CNT_W   = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             d_decoded,
   input  logic             data_enable,
   input  logic             sync_clear,
   output logic             d_unstuffed,
   output logic             bit_valid,
   output logic             unstuff_hold,
   output logic             stuff_err,
   output logic             stuff_err_pulse,
   output logic [CNT_W-1:0] run_count
);

   localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STUFF = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic [CNT_W-1:0] w_count_inc;
   logic             r_data;
   logic             w_data_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_hold;
   logic             r_err;
   logic             w_err_nxt;
   logic             r_err_pulse;
   logic             w_err_pulse_nxt;

   assign w_count_inc = r_count + CNT_W'(1);

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic; sync_clear drops any strobe in its cycle
   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_data_nxt      = r_data;
      w_valid_nxt     = 1'b0;
      w_err_nxt       = r_err;
      w_err_pulse_nxt = 1'b0;

      if (sync_clear) begin
         w_state_nxt = ST_RUN;
         w_count_nxt = '0;
         w_err_nxt   = 1'b0;
         w_data_nxt  = 1'b1;
      end else if (data_enable) begin
         case (r_state)
            ST_RUN: begin
               w_data_nxt  = d_decoded;
               w_valid_nxt = 1'b1;
               if (d_decoded) begin
                  w_count_nxt = w_count_inc;
                  if (w_count_inc == RUN_LEN_C) begin
                     w_state_nxt = ST_STUFF;
                  end
               end else begin
                  w_count_nxt = '0;
               end
            end
            ST_STUFF: begin
               // Stuffed bit is discarded; ones never carry across it
               w_count_nxt = '0;
               w_state_nxt = ST_RUN;
               if (d_decoded) begin
                  w_err_nxt       = 1'b1;
                  w_err_pulse_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
               w_count_nxt = '0;
            end
         endcase
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count     <= '0;
         r_data      <= 1'b1;
         r_valid     <= 1'b0;
         r_hold      <= 1'b0;
         r_err       <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_data      <= w_data_nxt;
         r_valid     <= w_valid_nxt;
         r_hold      <= (w_state_nxt == ST_STUFF);
         r_err       <= w_err_nxt;
         r_err_pulse <= w_err_pulse_nxt;
      end
   end

   assign d_unstuffed     = r_data;
   assign bit_valid       = r_valid;
   assign unstuff_hold    = r_hold;
   assign stuff_err       = r_err;
   assign stuff_err_pulse = r_err_pulse;
   assign run_count       = r_count;

endmodule

// File: doc/rx_bit_unstuffer.md
# rx_bit_unstuffer

Parametrised bit-unstuffer for the USB receive path. It sits between the NRZI decoder and the receive shift register. It counts consecutive decoded ones, deletes the stuffed bit that follows every run of RUN_LEN ones, and flags a stuff error when that bit is not 0. Unlike the first-generation unstuffer, it has a configurable run length, a per-bit valid strobe, packet-level synchronous clear, and error reporting.

## Interface
- RUN_LEN, 6: consecutive ones after which one stuffed bit follows; legal 2..15.
- CNT_W, 4: run counter width; must satisfy 2^CNT_W > RUN_LEN.
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- d_decoded  input  1  NRZI-decoded bit; sampled only when data_enable=1.
- data_enable  input  1  one-cycle strobe, one per received bit; any gap between strobes is legal.
- sync_clear  input  1  synchronous clear at SYNC detect or EOP; clears run state and error.
- d_unstuffed  output  1  registered data bit; holds its last value between strobes.
- bit_valid  output  1  one-cycle pulse, registered; high when d_unstuffed carries a real (non-stuffed) bit.
- unstuff_hold  output  1  registered level; high while the next strobed bit is a stuffed bit.
- stuff_err  output  1  sticky; set on a stuffed-bit violation.
- stuff_err_pulse  output  1  one-cycle pulse on the strobe that detects a violation.
- run_count  output  CNT_W  current consecutive-ones count (debug/observability).

## Operation
- Two states:
  - RUN: normal data.
  - STUFF: the next strobed bit is a stuffed bit.
- unstuff_hold = (state == STUFF), driven from a register.
- RUN, data_enable=1:
  - d_unstuffed <= d_decoded; bit_valid <= 1.
  - If d_decoded=1: run_count <= run_count+1. When the new count equals RUN_LEN, go to STUFF.
  - If d_decoded=0: run_count <= 0.
- STUFF, data_enable=1:
  - The bit is discarded: bit_valid <= 0 and d_unstuffed keeps its value.
  - run_count <= 0 and the state returns to RUN.
  - If d_decoded=1: stuff_err <= 1 and stuff_err_pulse <= 1.
- data_enable=0: state, count, and d_unstuffed hold; bit_valid <= 0; stuff_err_pulse <= 0.
- sync_clear=1 has priority over data_enable:
  - State goes to RUN; run_count, stuff_err, stuff_err_pulse, and bit_valid go to 0.
  - d_unstuffed <= 1 (idle).
  - The strobed bit in that cycle is dropped.
- stuff_err clears only on sync_clear or reset; the run counter keeps operating after an error.
- Ones that straddle a stuffed bit do not carry over: counting restarts at 0 after every stuffed bit.

## Timing
- Reset values: d_unstuffed=1, bit_valid=0, unstuff_hold=0, stuff_err=0, stuff_err_pulse=0, run_count=0, state=RUN.
- Latency: one clock from the data_enable edge to d_unstuffed/bit_valid.
- unstuff_hold rises in the cycle after the strobe that carries the RUN_LEN-th one. It falls in the cycle after the next strobe.
- stuff_err_pulse aligns with the cycle in which bit_valid would have been high; stuff_err rises in the same cycle.
- run_count never exceeds RUN_LEN. There is no wrap.
- Asserting n_rst mid-packet returns all outputs to their reset values immediately (asynchronous). The first strobe after release is treated as a RUN-state bit.
- Back-to-back strobes (data_enable held high) are supported at one bit per clock.

## Test plan
- Reset, then strobe 1,1,1,1,1,1,0,1 (RUN_LEN=6):
  - 6 bit_valid pulses with d_unstuffed=1.
  - unstuff_hold high between the 6th and 7th strobes.
  - The 7th strobe produces no bit_valid.
  - The 8th produces a bit_valid pulse with d_unstuffed=1; stuff_err stays 0.
- Strobe 1×6 then 1:
  - The 7th strobe produces stuff_err_pulse=1 with no bit_valid.
  - stuff_err stays high until a sync_clear pulse, after which it is 0.
- Strobe 1,1,1,1,1,0 repeated 3 times: unstuff_hold never asserts; 18 bit_valid pulses.
- Strobe 12 ones with a 0 after each run of 6:
  - 12 bit_valid pulses and 2 deleted bits.
  - run_count sequence 1..6,0,1..6,0.
- Send 4 ones, pulse sync_clear, then 2 ones: run_count reads 0 after the clear and 2 at the end; no hold.
- Random gaps of 0–5 cycles between strobes with RUN_LEN=3, CNT_W=2:
  - Stuffing every 3 ones is honoured.
  - n_rst asserted mid-run forces all outputs to their reset values.
